// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: shift-direction encoding and
// receive FSM states.
package serial_pkg;

    // Same encoding as the universal shift register's shift-left/shift-right select
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shift register with enable, direction and synchronous clear;
// exposes both the current value and the value it will load on the next edge.
module sipo_shift_core
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_dir,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    // Clear takes effect before the shift, so a clear+enable loads just the new bit
    always_comb begin
        w_base = i_clr ? '0 : r_q;
        w_next = w_base;
        if (i_en) begin
            if (i_dir == DIR_LSB_FIRST) begin
                w_next = {i_din, w_base[WIDTH-1:1]};
            end else begin
                w_next = {w_base[WIDTH-2:0], i_din};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q    = r_q;
    assign o_next = w_next;

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects a qualified serial bit stream into WIDTH-bit words with SOF resync,
// a one-word valid/ready output buffer and a sticky overrun flag.
module serial_word_deserializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_din,
    input  logic             s_valid,
    input  logic             s_sof,
    input  logic             dir,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_n;
    logic             r_dir_q;
    logic             w_dir_n;
    logic             w_first;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_unused_q;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk    (clk),
        .rst_n  (rst),
        .i_en   (s_valid),
        .i_clr  (w_first),
        .i_dir  (w_dir_n),
        .i_din  (s_din),
        .o_q    (w_unused_q),
        .o_next (w_word)
    );

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_dir_n    = r_dir_q;
        w_first    = 1'b0;
        w_complete = 1'b0;
        if (s_valid) begin
            w_first = s_sof || (r_state == IDLE);
            if (w_first) begin
                w_dir_n   = dir;
                w_cnt_n   = CW'(1);
                w_state_n = RECV;
            end else if (r_cnt == LAST) begin
                w_cnt_n    = '0;
                w_state_n  = IDLE;
                w_complete = 1'b1;
            end else begin
                w_cnt_n = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dir_q   <= 1'b0;
            r_busy    <= 1'b0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_dir_q <= w_dir_n;
            r_busy  <= (w_cnt_n != '0);
            // A drain on the completion edge frees the buffer for the new word
            if (w_complete && (!r_valid || p_ready)) begin
                r_dout  <= w_word;
                r_valid <= 1'b1;
            end else if (!w_complete && p_ready) begin
                r_valid <= 1'b0;
            end
            if (w_complete && r_valid && !p_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign p_dout  = r_dout;
    assign p_valid = r_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=8): expected words are queued
// as stimulus is driven and checked when the output handshake fires.
module tb_serial_word_deserializer;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             s_din = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_sof = 1'b0;
    logic             dir = 1'b0;
    logic             p_ready = 1'b0;
    logic             clr_overrun = 1'b0;
    logic [WIDTH-1:0] p_dout;
    logic             p_valid;
    logic             busy;
    logic             overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] sb_q[$];

    always #5 clk = ~clk;

    serial_word_deserializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_din       (s_din),
        .s_valid     (s_valid),
        .s_sof       (s_sof),
        .dir         (dir),
        .p_dout      (p_dout),
        .p_valid     (p_valid),
        .p_ready     (p_ready),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic d, input logic sof);
        s_valid = 1'b1;
        s_din   = d;
        s_sof   = sof;
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // seq[7] is the first bit on the wire
    task automatic send_seq(input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq[i], 1'b0);
        end
    endtask

    // Inputs change just after posedge, so at negedge p_valid && p_ready predicts a handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst && p_valid && p_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", {24'h0, p_dout}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_word", {24'h0, p_dout}, {24'h0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [7:0] seq;

        #3;
        check("rst_p_valid", p_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_p_dout", p_dout, 0);
        #10 rst = 1'b1;
        tick();

        // MSB-first, back to back
        dir     = 1'b0;
        p_ready = 1'b1;
        seq     = 8'hB2;
        sb_q.push_back(8'hB2);
        check("msb_busy_idle", busy, 0);
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq[i], 1'b0);
            check("msb_busy", busy, (i > 0) ? 1 : 0);
        end
        check("msb_valid", p_valid, 1);
        check("msb_dout", p_dout, 8'hB2);
        tick();
        check("msb_valid_drop", p_valid, 0);

        // LSB-first with gaps; dir flips mid-word and must be ignored
        dir = 1'b1;
        sb_q.push_back(8'h4D);
        for (int k = 0; k < 8; k++) begin
            bit_in(seq[7-k], 1'b0);
            if (k == 2) dir = 1'b0;
            if (k == 1 || k == 4) begin
                tick();
                check("lsb_gap_busy", busy, 1);
            end
        end
        check("lsb_valid", p_valid, 1);
        check("lsb_dout", p_dout, 8'h4D);
        tick();

        // Backpressure: second word dropped while overrun-clear is asserted
        p_ready = 1'b0;
        sb_q.push_back(8'hB2);
        send_seq(8'hB2);
        check("bp_valid", p_valid, 1);
        clr_overrun = 1'b1;
        send_seq(8'hFF);
        clr_overrun = 1'b0;
        check("bp_overrun_wins", overrun, 1);
        check("bp_dout_hold", p_dout, 8'hB2);
        check("bp_valid_hold", p_valid, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("bp_overrun_clr", overrun, 0);
        p_ready = 1'b1;
        tick();
        check("bp_valid_drop", p_valid, 0);

        // Drain and complete on the same edge
        p_ready = 1'b0;
        sb_q.push_back(8'hB2);
        send_seq(8'hB2);
        sb_q.push_back(8'h3C);
        seq = 8'h3C;
        for (int i = 7; i >= 1; i--) begin
            bit_in(seq[i], 1'b0);
        end
        p_ready = 1'b1;
        bit_in(seq[0], 1'b0);
        check("dc_dout", p_dout, 8'h3C);
        check("dc_valid", p_valid, 1);
        check("dc_overrun", overrun, 0);
        tick();
        check("dc_valid_drop", p_valid, 0);

        // SOF resync after junk
        dir = 1'b0;
        sb_q.push_back(8'hF0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("sof_junk_busy", busy, 1);
        bit_in(1'b1, 1'b1);
        seq = 8'hF0;
        for (int i = 6; i >= 0; i--) begin
            bit_in(seq[i], 1'b0);
        end
        check("sof_dout", p_dout, 8'hF0);
        check("sof_valid", p_valid, 1);
        tick();

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) begin
            bit_in(i[0], 1'b0);
        end
        check("mid_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", p_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_dout", p_dout, 0);
        #2 rst = 1'b1;
        tick();
        sb_q.push_back(8'hA5);
        send_seq(8'hA5);
        check("post_rst_dout", p_dout, 8'hA5);
        check("post_rst_valid", p_valid, 1);
        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
